// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with in-order imem requests, prefetch queue and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/squash_cnt performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        inst_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
`endif
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc, r_resp_pc;
  logic [CW-1:0] r_outstanding, r_qcount;
  logic [7:0]    r_discard;
  logic [PW-1:0] r_head, r_tail;
  logic [31:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];
  logic          w_accept, w_drop, w_push, w_pop, w_full;

  assign w_full    = r_qcount == CW'(QDEPTH);
  assign imem_req  = !rst && !branch_taken &&
                     ((CW+1)'(r_outstanding) + (CW+1)'(r_qcount) < (CW+1)'(QDEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;
  // a response in the redirect cycle belongs to the old path and is dropped
  assign w_drop    = imem_rvalid && (r_discard != 8'd0 || branch_taken);
  assign w_push    = imem_rvalid && !w_drop && !w_full;
  assign w_pop     = !branch_taken && !keep && r_qcount != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_qcount      <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_discard     <= 8'(r_outstanding);
    end else if (branch_taken) begin
      r_fetch_pc    <= branch_target & ~32'd3;
      r_resp_pc     <= branch_target & ~32'd3;
      r_outstanding <= '0;
      r_qcount      <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_discard     <= r_discard + 8'(r_outstanding) - 8'(imem_rvalid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
      if (imem_rvalid && r_discard != 8'd0) r_discard <= r_discard - 8'd1;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_push);
      r_qcount      <= r_qcount + CW'(w_push) - CW'(w_pop);
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop) r_head <= r_head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_pc[r_tail]   <= r_resp_pc;
      r_q_inst[r_tail] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      PC_pype0         <= '0;
      PCp4_pype0       <= '0;
      Instraction_pype <= NOP;
      inst_valid       <= 1'b0;
    end else if (!keep) begin
      inst_valid       <= w_pop;
      Instraction_pype <= w_pop ? r_q_inst[r_head] : NOP;
      if (w_pop) begin
        PC_pype0   <= r_q_pc[r_head];
        PCp4_pype0 <= r_q_pc[r_head] + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      fetch_cnt  <= fetch_cnt + 32'(w_pop);
      squash_cnt <= squash_cnt + 32'(w_drop) + (branch_taken ? 32'(r_qcount) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle directed vectors driving the imem handshake and checking fetch_stage outputs.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1, keep = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
  logic        inst_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, squash_cnt;
`endif
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .keep(keep), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0), .Instraction_pype(Instraction_pype),
    .inst_valid(inst_valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
`endif
  );

  typedef struct {
    logic        rst, keep, br;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, pc, pcp4, ins;
    logic        val;
    logic [31:0] fc, sc;
  } vec_t;

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    vec_t v [30];
    v[0]  = '{1,0,0,0,           0,0,0,            0,32'h100, 0,0,32'h13,0,                  0,0};
    v[1]  = '{0,0,0,0,           1,0,0,            1,32'h100, 0,0,32'h13,0,                  0,0};
    v[2]  = '{0,0,0,0,           1,1,32'hA5A50100, 1,32'h104, 0,0,32'h13,0,                  0,0};
    v[3]  = '{0,0,0,0,           1,1,32'hA5A50104, 0,32'h108, 0,0,32'h13,0,                  0,0};
    v[4]  = '{0,1,0,0,           1,0,0,            1,32'h108, 32'h100,32'h104,32'hA5A50100,1, 1,0};
    v[5]  = '{0,1,0,0,           1,1,32'hA5A50108, 0,32'h10C, 32'h100,32'h104,32'hA5A50100,1, 1,0};
    v[6]  = '{0,1,0,0,           1,0,0,            0,32'h10C, 32'h100,32'h104,32'hA5A50100,1, 1,0};
    v[7]  = '{0,0,0,0,           1,0,0,            0,32'h10C, 32'h100,32'h104,32'hA5A50100,1, 1,0};
    v[8]  = '{0,0,0,0,           0,0,0,            1,32'h10C, 32'h104,32'h108,32'hA5A50104,1, 2,0};
    v[9]  = '{0,0,0,0,           0,0,0,            1,32'h10C, 32'h108,32'h10C,32'hA5A50108,1, 3,0};
    v[10] = '{0,0,0,0,           0,0,0,            1,32'h10C, 32'h108,32'h10C,32'h13,0,       3,0};
    v[11] = '{0,0,0,0,           0,0,0,            1,32'h10C, 32'h108,32'h10C,32'h13,0,       3,0};
    v[12] = '{0,0,0,0,           1,0,0,            1,32'h10C, 32'h108,32'h10C,32'h13,0,       3,0};
    v[13] = '{0,0,0,0,           1,0,0,            1,32'h110, 32'h108,32'h10C,32'h13,0,       3,0};
    v[14] = '{0,0,1,32'h2003,    1,0,0,            0,32'h114, 32'h108,32'h10C,32'h13,0,       3,0};
    v[15] = '{0,0,0,0,           1,1,32'hDEAD010C, 1,32'h2000,0,0,32'h13,0,                  3,0};
    v[16] = '{0,0,0,0,           1,1,32'hDEAD0110, 1,32'h2004,0,0,32'h13,0,                  3,1};
    v[17] = '{0,0,0,0,           1,0,0,            0,32'h2008,0,0,32'h13,0,                  3,2};
    v[18] = '{0,0,0,0,           1,1,32'hA5A52000, 0,32'h2008,0,0,32'h13,0,                  3,2};
    v[19] = '{0,0,0,0,           1,1,32'hA5A52004, 0,32'h2008,0,0,32'h13,0,                  3,2};
    v[20] = '{0,1,0,0,           1,0,0,            1,32'h2008,32'h2000,32'h2004,32'hA5A52000,1,4,2};
    v[21] = '{0,1,1,32'h3000,    1,1,32'hDEAD2008, 0,32'h200C,32'h2000,32'h2004,32'hA5A52000,1,4,2};
    v[22] = '{0,0,0,0,           1,0,0,            1,32'h3000,0,0,32'h13,0,                  4,4};
    v[23] = '{0,0,0,0,           1,1,32'hA5A53000, 1,32'h3004,0,0,32'h13,0,                  4,4};
    v[24] = '{0,0,0,0,           0,0,0,            0,32'h3008,0,0,32'h13,0,                  4,4};
    v[25] = '{1,0,0,0,           0,0,0,            0,32'h3008,32'h3000,32'h3004,32'hA5A53000,1,5,4};
    v[26] = '{0,0,0,0,           1,1,32'hDEAD0000, 1,32'h100, 0,0,32'h13,0,                  0,0};
    v[27] = '{0,0,0,0,           1,1,32'h5A5A0100, 1,32'h104, 0,0,32'h13,0,                  0,1};
    v[28] = '{0,0,0,0,           1,0,0,            0,32'h108, 0,0,32'h13,0,                  0,1};
    v[29] = '{0,0,0,0,           0,0,0,            1,32'h108, 32'h100,32'h104,32'h5A5A0100,1,1,1};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      rst = v[i].rst; keep = v[i].keep; branch_taken = v[i].br; branch_target = v[i].tgt;
      imem_ready = v[i].rdy; imem_rvalid = v[i].rv; imem_rdata = v[i].rdata;
      @(negedge clk);
      n_vec++;
      chk(i, "imem_req", {31'd0, imem_req}, {31'd0, v[i].req});
      chk(i, "imem_addr", imem_addr, v[i].addr);
      chk(i, "PC_pype0", PC_pype0, v[i].pc);
      chk(i, "PCp4_pype0", PCp4_pype0, v[i].pcp4);
      chk(i, "Instraction_pype", Instraction_pype, v[i].ins);
      chk(i, "inst_valid", {31'd0, inst_valid}, {31'd0, v[i].val});
`ifdef FETCH_PERF_CNT_EN
      chk(i, "fetch_cnt", fetch_cnt, v[i].fc);
      chk(i, "squash_cnt", squash_cnt, v[i].sc);
`endif
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline. Sits directly upstream of decode.
- Issues in-order instruction-memory requests, buffers returned words in a small prefetch queue, and drives the IF/ID pipeline register.
- Outputs to decode: PC_pype0, PCp4_pype0, Instraction_pype.
- Handles stall (keep) and branch/jump redirect from EX, including squashing of in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, prefetch queue entries; power of two, range 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- keep  in  1  hold the IF/ID register (hazard stall).
- branch_taken  in  1  redirect request from EX (one-cycle pulse).
- branch_target  in  32  redirect address.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (word aligned).
- imem_ready  in  1  request accepted when imem_req&&imem_ready.
- imem_rvalid  in  1  response valid; exactly one per accepted request, in order, latency >=1.
- imem_rdata  in  32  response word.
- PC_pype0  out  32  PC of the instruction in IF/ID.
- PCp4_pype0  out  32  PC_pype0+4.
- Instraction_pype  out  32  instruction word to decode.
- inst_valid  out  1  IF/ID holds a real instruction; decode treats !inst_valid as a nop.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - fetch_pc=RESET_PC; queue, outstanding and discard counters = 0.
  - PC_pype0=0, PCp4_pype0=0, Instraction_pype=32'h0000_0013, inst_valid=0, imem_req=0.
  - rst asserted mid-transaction: all state cleared. Responses to requests accepted before reset count toward discard: discard=outstanding at reset.
- Request side:
  - imem_req=1 when !branch_taken && (outstanding+qcount) < QDEPTH.
  - imem_addr=fetch_pc.
  - On accept: fetch_pc += 4 (mod 2^32 wrap), outstanding++.
- Response side:
  - imem_rvalid with discard>0: word dropped, discard--.
  - Otherwise the word and its PC are pushed into the queue; outstanding--.
  - Queue never overflows by construction (credit rule). An rvalid that would overflow is a protocol error and asserts no state change.
- IF/ID register:
  - branch_taken=1, regardless of keep: Instraction_pype=32'h13, inst_valid=0, PC outputs=0.
  - Else keep=1: all IF/ID outputs hold; the queue does not pop.
  - Else queue non-empty: pop head into the outputs, inst_valid=1, PCp4_pype0=PC+4.
  - Else (queue empty): bubble, Instraction_pype=32'h13, inst_valid=0, PC outputs hold.
- Bypass: a response arriving into an empty queue is visible at IF/ID one cycle after imem_rvalid (push, then pop). Minimum fetch-to-decode latency is imem latency + 1 cycle.
- Redirect (branch_taken):
  - Queue flushed.
  - fetch_pc=branch_target with bits [1:0] forced to 0.
  - discard = outstanding minus 1 if an rvalid arrives in the same cycle (that response is dropped).
  - outstanding=0. No request is issued in the redirect cycle; fetching resumes the next cycle.
  - Redirect while discard>0 accumulates the discard count.
- Simultaneous push and pop in one cycle: qcount unchanged. Queue pointers wrap modulo QDEPTH.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds output ports fetch_cnt[31:0] and squash_cnt[31:0], reset to 0.
  - fetch_cnt increments on every pop into IF/ID.
  - squash_cnt increments on every dropped response, plus the number of queue entries flushed on a redirect.
  - Both counters wrap at 2^32.
- Macro undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, then release; memory has latency 1 and is always ready -> requests to 0x100, 0x104, 0x108...; IF/ID shows PC 0x100 with inst_valid=1 on the 3rd cycle after rst falls; PCp4_pype0=0x104.
- Streaming, then keep high 3 cycles -> IF/ID holds the same PC/instruction; no more than QDEPTH requests outstanding; after keep drops, the sequence continues with no gap and no duplicate.
- imem_ready low 4 cycles -> imem_addr stable at the same value; IF/ID shows bubbles (0x13, inst_valid=0) once the queue drains.
- Memory latency 3 with 2 outstanding, branch_taken to 0x2003 -> both stale responses are dropped; next request addr is 0x2000; first valid IF/ID entry has PC 0x2000.
- branch_taken and keep asserted together, with rvalid in the same cycle -> IF/ID becomes a bubble; the response is dropped; fetching restarts at the target the next cycle.
- With FETCH_PERF_CNT_EN defined, run the redirect scenario -> squash_cnt=2; fetch_cnt equals the number of inst_valid pops.
